// File: rtl/module_input_gray_debounce_pkg.sv
// Shared types and helpers for the Gray/binary input debouncer and its refresh tick.
package module_input_gray_debounce_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_JUMP = 2'd3
  } step_e;

  // Prefix-XOR from the MSB; zero-extended inputs decode identically at any narrower width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned input_refresh,
                                   input int unsigned stable_samples);
    return (width >= 2) && (width <= GRAY_MAX_W) &&
           (input_refresh >= 2) && (stable_samples >= 1);
  endfunction

endpackage

// File: rtl/module_refresh_tick.sv
// Free-running down-counter emitting a one-cycle tick every INPUT_REFRESH cycles.
module module_refresh_tick #(
  parameter int unsigned INPUT_REFRESH = 2700000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (INPUT_REFRESH > 1) ? $clog2(INPUT_REFRESH) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(INPUT_REFRESH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q - CW'(1);
    tick_d = 1'b0;
    if (cnt_q == '0) begin
      cnt_d  = RELOAD;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q  <= RELOAD;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/module_input_gray_debounce.sv
// Synchronise, decode, debounce and classify a WIDTH-bit pin code sampled on a refresh tick.
module module_input_gray_debounce
  import module_input_gray_debounce_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned INPUT_REFRESH  = 2700000,
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] code_i,
  input  logic             gray_mode_i,
  output logic [WIDTH-1:0] bin_code_o,
  output logic             code_valid_o,
  output logic             dir_up_o,
  output logic             dir_dn_o,
  output logic             jump_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES);

  generate
    if (!params_ok(WIDTH, INPUT_REFRESH, STABLE_SAMPLES)) begin : g_bad_params
      $error("module_input_gray_debounce: illegal parameter combination");
    end
  endgenerate

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q;
  logic             valid_q, up_q, dn_q, jump_q;
  logic             tick;
  logic [WIDTH-1:0] s_c;
  logic [WIDTH-1:0] diff_c;
  logic             commit_c;
  step_e            step_c;

  module_refresh_tick #(
    .INPUT_REFRESH(INPUT_REFRESH)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

  // gray_mode_i is quasi-static, so it feeds the decode without synchronisation.
  assign s_c = gray_mode_i ? WIDTH'(gray2bin(GRAY_MAX_W'(sync2_q))) : sync2_q;

  // Debounce and step classification; state only moves on a tick.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    step_c   = STEP_NONE;
    if (tick) begin
      if (s_c != cand_q) begin
        cand_d = s_c;
        cnt_d  = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      commit_c = (cnt_d == CNT_MAX) && (cand_d != bin_q);
    end
    diff_c = cand_d - bin_q;
    if (commit_c) begin
      if (diff_c == WIDTH'(1)) begin
        step_c = STEP_UP;
      end else if (diff_c == '1) begin
        step_c = STEP_DN;
      end else begin
        step_c = STEP_JUMP;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      sync1_q <= code_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      valid_q <= commit_c;
      up_q    <= (step_c == STEP_UP);
      dn_q    <= (step_c == STEP_DN);
      jump_q  <= (step_c == STEP_JUMP);
      if (commit_c) begin
        bin_q <= cand_d;
      end
    end
  end

  assign bin_code_o   = bin_q;
  assign code_valid_o = valid_q;
  assign dir_up_o     = up_q;
  assign dir_dn_o     = dn_q;
  assign jump_o       = jump_q;

endmodule

// File: doc/module_input_gray_debounce.md
# module_input_gray_debounce

Parametrised input conditioner for a WIDTH-bit code source such as switches, absolute rotary encoders or DIP banks. It synchronises the pins into the clock domain and samples them on a periodic refresh tick. The sampled code is decoded as Gray or passed through as plain binary. A value is committed only after it has been stable for STABLE_SAMPLES consecutive ticks, and each commit is reported as a step up, a step down or a jump. It sits between the board pins and the application logic (display and control FSMs).

## Interface
Parameters:
- WIDTH, 4, code width in bits; must be >= 2
- INPUT_REFRESH, 2700000, clock cycles per sampling tick; must be >= 2
- STABLE_SAMPLES, 3, consecutive equal ticks required to commit; must be >= 1

Ports:
- clk_i  input  1  single system clock; all logic is on its rising edge
- rst_i  input  1  synchronous, active-low reset
- code_i  input  WIDTH  raw asynchronous code from the pins
- gray_mode_i  input  1  1 = decode code_i as reflected Gray; 0 = treat code_i as binary
- bin_code_o  output  WIDTH  committed binary value
- code_valid_o  output  1  one-cycle pulse, high in the cycle bin_code_o takes a new value
- dir_up_o  output  1  one-cycle pulse with code_valid_o when new = old + 1 mod 2^WIDTH
- dir_dn_o  output  1  one-cycle pulse with code_valid_o when new = old - 1 mod 2^WIDTH
- jump_o  output  1  one-cycle pulse with code_valid_o for any other change

## Operation
- **Synchroniser:** 2-FF synchroniser on code_i, clocked every cycle. gray_mode_i is treated as quasi-static and is not synchronised.
- **Refresh counter:**
  - Loads INPUT_REFRESH-1 at reset and counts down once per cycle.
  - At 0 it reloads and produces tick for one cycle, so the tick period is exactly INPUT_REFRESH cycles.
  - Counter width is $clog2(INPUT_REFRESH).
- **Decode:** s = gray_mode_i ? gray2bin(sync) : sync, where gray2bin gives b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
- **Debounce (on tick only; all state holds on non-tick cycles):**
  - If s != cand: cand <= s, cnt <= 1.
  - Otherwise cnt <= min(cnt+1, STABLE_SAMPLES).
  - commit = (updated cnt == STABLE_SAMPLES) && (cand_next != bin_code_o).
- **Commit:**
  - bin_code_o <= cand_next and code_valid_o <= 1.
  - Exactly one of dir_up_o, dir_dn_o or jump_o is set, classified by WIDTH-bit modular subtraction new - old: 1 gives up, all-ones gives down, anything else gives jump.
  - Wrap-around is a step: 2^WIDTH-1 to 0 is up, and 0 to 2^WIDTH-1 is down.
- **Pulse outputs:** all four pulses are 0 in every cycle without a commit.
- **Mode change:** toggling gray_mode_i changes s. This restarts debouncing exactly like an input change, and the eventual commit is classified normally. There is no special handling.
- **Width rules:**
  - cnt width is $clog2(STABLE_SAMPLES+1) and cnt saturates, so a long stable input never retriggers.
  - A value equal to bin_code_o never commits.
- **Reset** (rst_i low at a clock edge, including mid-debounce):
  - bin_code_o = 0; code_valid_o, dir_up_o, dir_dn_o and jump_o = 0.
  - cand = 0, cnt = 0, synchroniser flops = 0, refresh counter = INPUT_REFRESH-1.
  - Any in-progress debounce is discarded.

## Timing
- code_i to visibility in s: 2 cycles (synchroniser).
- Tick in cycle T to commit visible on bin_code_o and pulses: T+1 (registered outputs).
- First tick after reset release: INPUT_REFRESH cycles after the first non-reset edge.
- Worst-case latency from a stable input change to commit: 2 + STABLE_SAMPLES*INPUT_REFRESH + 1 cycles.
- With STABLE_SAMPLES = 1, a change commits on the first tick that sees it.
- An input glitch shorter than one tick period that is not present at a tick is invisible.
- A glitch caught at one tick resets cnt, delaying the commit without corrupting bin_code_o.

## Structure
- The shared package/include holds:
  - function gray2bin(WIDTH-generic)
  - step-classification encodings (UP, DN, JUMP)
  - parameter-legality checks (WIDTH >= 2, INPUT_REFRESH >= 2, STABLE_SAMPLES >= 1)
- One natural sub-module: module_refresh_tick (parameter INPUT_REFRESH; ports clk_i, rst_i, tick_o). It is reusable by other input blocks.
- Synchroniser, debounce and classifier stay in this module.

## Test plan
Settings: WIDTH=4, INPUT_REFRESH=4, STABLE_SAMPLES=3.

1. **Reset values:** hold rst_i low for 5 cycles with code_i=4'b1010 -> bin_code_o=0, no pulses; the first tick comes 4 cycles after release.
2. **Gray step up:** gray_mode_i=1, code_i 0000 -> 0001, held -> after 3 ticks bin_code_o=1, with code_valid_o and dir_up_o pulsing for exactly 1 cycle.
3. **Gray wrap:** starting from committed 4'b1111 (Gray 1000), apply Gray 0000 -> bin_code_o=0 and dir_up_o; then apply Gray 1000 -> bin_code_o=15 and dir_dn_o.
4. **Bounce rejection:** present 0011 for 2 ticks, 0001 for 1 tick, then 0011 steadily -> commit (bin 2) only after 3 further consecutive ticks; no intermediate pulses.
5. **Binary mode jump:** gray_mode_i=0, committed value 2, code_i=9 -> bin_code_o=9 and jump_o; holding 9 for 10 more ticks produces no further pulses.
6. **Reset mid-debounce:** after 2 stable ticks of a new value, pulse rst_i low for 1 cycle -> bin_code_o=0, and the new value needs a full 3 ticks to commit.
